// File: rtl/barrel_hit_ctrl_if.sv
// Bus between the collision logic / frame timing and barrel_hit_ctrl.
// The master drives game state and overlap flags; the slave returns hits and sprite status.
interface barrel_hit_ctrl_if #(
    parameter int N_BARRELS = 10
);
    logic                 game_en;
    logic                 frame_tick;
    logic [N_BARRELS-1:0] collide;
    logic [N_BARRELS-1:0] hit;
    logic                 invuln;
    logic                 blink;
    logic [1:0]           lives_lost;

    modport master (
        output game_en, frame_tick, collide,
        input  hit, invuln, blink, lives_lost
    );

    modport slave (
        input  game_en, frame_tick, collide,
        output hit, invuln, blink, lives_lost
    );
endinterface

// File: rtl/barrel_hit_ctrl.sv
// Turns per-barrel overlap levels into single hit pulses, with a frame-counted
// invulnerability window, player blink enable and a lives-lost lockout.
module barrel_hit_ctrl #(
    parameter int N_BARRELS     = 10,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8,
    parameter int MAX_LIVES     = 3
) (
    input  logic              clk,
    input  logic              rst,
    barrel_hit_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_INVULN,
        ST_DEAD
    } state_e;

    state_e               state_q;
    logic [N_BARRELS-1:0] collide_prev_q;
    logic [N_BARRELS-1:0] hit_q;
    logic                 invuln_q;
    logic                 blink_q;
    logic [1:0]           lives_q;
    logic [7:0]           inv_cnt_q;
    logic [7:0]           blink_cnt_q;

    logic [N_BARRELS-1:0] rise;
    logic [N_BARRELS-1:0] hit_d;
    logic [1:0]           lives_d;

    // Isolate the lowest set bit: simultaneous rises collapse to one reported hit.
    function automatic logic [N_BARRELS-1:0] lowest_onehot(input logic [N_BARRELS-1:0] v);
        return v & (~v + N_BARRELS'(1));
    endfunction

    assign rise    = bus.collide & ~collide_prev_q;
    assign hit_d   = lowest_onehot(rise);
    assign lives_d = lives_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            collide_prev_q <= '0;
            hit_q          <= '0;
            invuln_q       <= 1'b0;
            blink_q        <= 1'b1;
            lives_q        <= 2'd0;
            inv_cnt_q      <= 8'd0;
            blink_cnt_q    <= 8'd0;
        end else begin
            collide_prev_q <= bus.collide;
            hit_q          <= '0;
            if (!bus.game_en) begin
                state_q     <= ST_IDLE;
                invuln_q    <= 1'b0;
                blink_q     <= 1'b1;
                lives_q     <= 2'd0;
                inv_cnt_q   <= 8'd0;
                blink_cnt_q <= 8'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q  <= ST_ARMED;
                        invuln_q <= 1'b0;
                        blink_q  <= 1'b1;
                        lives_q  <= 2'd0;
                    end
                    ST_ARMED: begin
                        if (|rise) begin
                            hit_q   <= hit_d;
                            lives_q <= lives_d;
                            if (lives_d == 2'(MAX_LIVES)) begin
                                state_q <= ST_DEAD;
                            end else begin
                                state_q     <= ST_INVULN;
                                inv_cnt_q   <= 8'(INVULN_FRAMES);
                                blink_cnt_q <= 8'(BLINK_FRAMES);
                                invuln_q    <= 1'b1;
                                blink_q     <= 1'b0;
                            end
                        end
                    end
                    ST_INVULN: begin
                        if (bus.frame_tick) begin
                            if (inv_cnt_q == 8'd1) begin
                                state_q  <= ST_ARMED;
                                invuln_q <= 1'b0;
                                blink_q  <= 1'b1;
                            end else begin
                                inv_cnt_q <= inv_cnt_q - 8'd1;
                                // Blink half-period expires on the tick that would take the count to zero.
                                if (blink_cnt_q == 8'd1) begin
                                    blink_q     <= ~blink_q;
                                    blink_cnt_q <= 8'(BLINK_FRAMES);
                                end else begin
                                    blink_cnt_q <= blink_cnt_q - 8'd1;
                                end
                            end
                        end
                    end
                    ST_DEAD: begin
                        invuln_q <= 1'b0;
                        blink_q  <= 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.hit        = hit_q;
    assign bus.invuln     = invuln_q;
    assign bus.blink      = blink_q;
    assign bus.lives_lost = lives_q;

endmodule

// File: tb/tb_barrel_hit_ctrl.sv
// Directed test-plan scenarios followed by random stimulus, all checked every
// cycle against a frame-count reference model of the hit controller.
module tb_barrel_hit_ctrl;

    localparam int NB    = 10;
    localparam int INV   = 120;
    localparam int BLK   = 8;
    localparam int LIVES = 3;

    logic clk;
    logic rst;

    barrel_hit_ctrl_if #(.N_BARRELS(NB)) bus ();

    barrel_hit_ctrl #(
        .N_BARRELS    (NB),
        .INVULN_FRAMES(INV),
        .BLINK_FRAMES (BLK),
        .MAX_LIVES    (LIVES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: game running flag, lives, and frames elapsed since the last hit.
    bit          m_running;
    int          m_lives;
    bit          m_window;
    int          m_elapsed;
    logic [NB-1:0] m_prev;
    logic [NB-1:0] m_hit;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic ge, input logic ft, input logic [NB-1:0] c);
        logic [NB-1:0] rise;
        int idx;
        rise   = c & ~m_prev;
        m_prev = c;
        m_hit  = '0;
        if (r) begin
            m_running = 0; m_lives = 0; m_window = 0; m_elapsed = 0; m_prev = '0;
        end else if (!ge) begin
            m_running = 0; m_lives = 0; m_window = 0;
        end else if (!m_running) begin
            m_running = 1;
        end else if (m_lives == LIVES) begin
            // locked out: nothing changes until the game stops
        end else if (m_window) begin
            if (ft) begin
                m_elapsed++;
                if (m_elapsed == INV) m_window = 0;
            end
        end else if (rise != '0) begin
            idx = 0;
            for (int i = NB - 1; i >= 0; i--) if (rise[i]) idx = i;
            m_hit = '0;
            m_hit[idx] = 1'b1;
            m_lives++;
            if (m_lives < LIVES) begin
                m_window  = 1;
                m_elapsed = 0;
            end
        end
    endtask

    task automatic step();
        logic r, ge, ft;
        logic [NB-1:0] c;
        logic exp_blink;
        r  = rst;
        ge = bus.game_en;
        ft = bus.frame_tick;
        c  = bus.collide;
        @(posedge clk);
        model_update(r, ge, ft, c);
        #1;
        exp_blink = m_window ? (((m_elapsed / BLK) % 2) == 1) : 1'b1;
        chk_eq("hit",    32'(bus.hit),        32'(m_hit));
        chk_eq("invuln", 32'(bus.invuln),     32'(m_window));
        chk_eq("blink",  32'(bus.blink),      32'(exp_blink));
        chk_eq("lives",  32'(bus.lives_lost), 32'(m_lives));
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        m_running = 0; m_lives = 0; m_window = 0; m_elapsed = 0; m_prev = '0; m_hit = '0;
        rst = 1'b1;
        bus.game_en    = 1'b0;
        bus.frame_tick = 1'b0;
        bus.collide    = '0;
        step();
        step();
        chk_eq("rst_hit",   32'(bus.hit),        32'h0);
        chk_eq("rst_blink", 32'(bus.blink),      32'h1);
        chk_eq("rst_lives", 32'(bus.lives_lost), 32'h0);
        rst = 1'b0;
        bus.game_en = 1'b1;
        step();
        step();

        // Single hit on barrel 3, held for several cycles
        bus.collide[3] = 1'b1;
        step();
        chk_eq("single_hit",    32'(bus.hit),        32'h008);
        chk_eq("single_lives",  32'(bus.lives_lost), 32'h1);
        chk_eq("single_invuln", 32'(bus.invuln),     32'h1);
        chk_eq("single_blink",  32'(bus.blink),      32'h0);
        step();
        chk_eq("single_pulse", 32'(bus.hit), 32'h0);
        step(); step(); step();
        bus.collide[3] = 1'b0;

        // Invulnerability: blink cadence, ignored re-pulse, window end
        tick_n(8);
        chk_eq("blink_after8", 32'(bus.blink), 32'h1);
        bus.collide[5] = 1'b1;
        step();
        chk_eq("inv_ignored", 32'(bus.hit), 32'h0);
        bus.collide[5] = 1'b0;
        step();
        tick_n(111);
        chk_eq("inv_119", 32'(bus.invuln), 32'h1);
        tick_n(1);
        chk_eq("inv_end",       32'(bus.invuln), 32'h0);
        chk_eq("inv_end_blink", 32'(bus.blink),  32'h1);
        bus.collide[5] = 1'b1;
        step();
        chk_eq("rehit5",       32'(bus.hit),        32'h020);
        chk_eq("rehit5_lives", 32'(bus.lives_lost), 32'h2);

        // Held overlap through the whole window never hits
        bus.collide[0] = 1'b1;
        step();
        tick_n(INV);
        step(); step(); step();
        chk_eq("held_nohit", 32'(bus.hit), 32'h0);
        bus.collide[0] = 1'b0;
        step();
        bus.collide[0] = 1'b1;
        step();
        chk_eq("held_rehit",  32'(bus.hit),        32'h001);
        chk_eq("dead_lives",  32'(bus.lives_lost), 32'h3);
        step();
        bus.collide[4] = 1'b1;
        step();
        chk_eq("dead_nohit", 32'(bus.hit),        32'h0);
        chk_eq("dead_hold",  32'(bus.lives_lost), 32'h3);
        chk_eq("dead_blink", 32'(bus.blink),      32'h1);

        // Simultaneous rises report only the lowest barrel
        bus.game_en = 1'b0;
        bus.collide = '0;
        step();
        chk_eq("off_lives", 32'(bus.lives_lost), 32'h0);
        bus.game_en = 1'b1;
        step();
        bus.collide[2] = 1'b1;
        bus.collide[7] = 1'b1;
        step();
        chk_eq("simul_hit",   32'(bus.hit),        32'h004);
        chk_eq("simul_lives", 32'(bus.lives_lost), 32'h1);

        // Abort mid-window with a same-cycle rise
        tick_n(5);
        bus.game_en    = 1'b0;
        bus.collide[9] = 1'b1;
        step();
        chk_eq("abort_hit",    32'(bus.hit),        32'h0);
        chk_eq("abort_invuln", 32'(bus.invuln),     32'h0);
        chk_eq("abort_blink",  32'(bus.blink),      32'h1);
        chk_eq("abort_lives",  32'(bus.lives_lost), 32'h0);
        bus.game_en = 1'b1;
        step();
        step();
        bus.collide[1] = 1'b1;
        step();
        chk_eq("rearm_hit", 32'(bus.hit), 32'h002);

        // Random phase
        for (int cyc = 0; cyc < 15000; cyc++) begin
            rst = ($urandom_range(0, 1999) == 0);
            if (bus.game_en) begin
                if ($urandom_range(0, 799) == 0) bus.game_en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.game_en = 1'b1;
            end
            bus.frame_tick = 1'($urandom_range(0, 1));
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 59) == 0) bus.collide[b] = ~bus.collide[b];
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/barrel_hit_ctrl.md
Name: barrel_hit_ctrl

Overview:
- Sits directly upstream of the game control FSM and produces its `hit[9:0]` input.
- Converts raw per-barrel overlap flags (Donkey sprite vs barrel, level signals from the collision logic) into clean one-cycle hit pulses.
- Enforces a post-hit invulnerability window, counted in frames, and drives a blink enable for the player sprite during that window.
- Tracks lives lost and stops reporting hits once all lives are gone.

Parameters:
- N_BARRELS, 10, number of barrel collision inputs/hit outputs.
- INVULN_FRAMES, 120, frame ticks of invulnerability after a hit (1..255).
- BLINK_FRAMES, 8, frame ticks per blink half-period (1..INVULN_FRAMES).
- MAX_LIVES, 3, hits accepted before the block locks (1..3).

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst  in  1  synchronous, active-high reset.
- game_en  in  1  high while a game is running; low forces idle.
- frame_tick  in  1  one-cycle pulse per video frame (start of vblank).
- collide  in  N_BARRELS  level overlap flag per barrel, synchronous to clk.
- hit  out  N_BARRELS  registered one-cycle pulse; at most one bit set.
- invuln  out  1  high while the invulnerability window is active.
- blink  out  1  sprite-visible enable; 1 outside invulnerability.
- lives_lost  out  2  count of accepted hits, saturating at MAX_LIVES.

Behaviour:
- Reset, all registered outputs: hit=0, invuln=0, blink=1, lives_lost=0, collide_prev=0, state=ST_IDLE, counters=0.
- collide_prev is registered every cycle in all states (<= collide). rise = collide & ~collide_prev.
- States:
  - ST_IDLE: outputs as at reset, except lives_lost=0 as well. Go to ST_ARMED when game_en=1.
  - ST_ARMED: if rise≠0, hit <= one-hot of the lowest-index set bit of rise for exactly 1 cycle, and lives_lost <= lives_lost+1.
    - If the new lives_lost == MAX_LIVES, go to ST_DEAD.
    - Otherwise go to ST_INVULN, with inv_cnt <= INVULN_FRAMES, blink_cnt <= BLINK_FRAMES, invuln <= 1, blink <= 0.
  - ST_INVULN: rises are ignored (no hit, no count).
    - On frame_tick: inv_cnt decrements. blink_cnt decrements; when it reaches 0, blink toggles and blink_cnt reloads BLINK_FRAMES.
    - On the frame_tick where inv_cnt==1, go to ST_ARMED with invuln <= 0 and blink <= 1.
  - ST_DEAD: hit=0, invuln=0, blink=1, lives_lost held. Leaves only via game_en=0 or rst.
- game_en=0 in any state: next cycle state=ST_IDLE, hit=0, invuln=0, blink=1, lives_lost=0. game_en overrides a simultaneous rise.
- Latency: collide rising at cycle N (sampled at edge N) gives hit high at cycle N+1 for one cycle.
- Hits are edge-based only:
  - A barrel still overlapping when invulnerability ends does not produce a hit.
  - That barrel must deassert and reassert collide to register.
  - A barrel that is high continuously from game_en rise also never hits.
- Simultaneous rises on several barrels count as one hit. Only the lowest index is reported; the others are discarded.
- frame_tick in the same cycle as a hit does not decrement the freshly loaded inv_cnt.
- Arithmetic:
  - inv_cnt is 8-bit; blink_cnt is 8-bit.
  - lives_lost is 2-bit, never exceeds MAX_LIVES.
- rst mid-window: immediate return to reset values on the next edge.

Test Plan:
- Single hit: rst, game_en=1, collide[3] 0→1 held for 5 cycles → hit=10'b0000001000 for exactly 1 cycle (1 cycle after the rise), lives_lost=1, invuln=1, blink=0.
- Simultaneous: collide[2] and collide[7] rise in the same cycle → hit=10'b0000000100 only, lives_lost=1.
- Invulnerability: after a hit, re-pulse collide[5] within 120 frame_ticks → no hit. blink toggles every 8 ticks. invuln drops on the 120th tick, blink=1. A new collide[5] rise afterwards → hit[5], lives_lost=2.
- Lockout: three separated hits → lives_lost=3 and state DEAD. A fourth rise → hit stays 0, lives_lost stays 3.
- Held overlap: collide[0] held high through the entire invulnerability window → no hit at window end. Drop and re-raise it → hit[0].
- Abort: game_en→0 mid-invulnerability with a same-cycle collide rise → next cycle hit=0, invuln=0, blink=1, lives_lost=0. game_en→1 → ARMED.
